// File: rtl/paddle_game_engine.sv
// ---------------------------------------------------------------------------
// paddle_game_engine
//   Ball-and-paddle game core sitting behind a VGA timing controller. Game
//   state advances once per frame (frame tick = y_pix==V_RES && x_pix==0);
//   pixel colour is produced one cycle after the incoming coordinates.
//
// Ports
//   pix_clk            pixel clock
//   reset              synchronous, active-high
//   btn_left/right     paddle move levels (already synchronised)
//   btn_serve          start / restart
//   x_pix, y_pix       current pixel coordinates
//   de_in              display enable from the timing controller
//   de_out             de_in delayed one cycle
//   r_out/g_out/b_out  COLOR_W-bit colour channels (0 while de is low)
//   game_state         IDLE=0 SERVE=1 PLAY=2 MISS=3 OVER=4
//   lives_left         remaining lives
//   score              paddle hits, saturating at 255
//
// Build option
//   SPEEDUP_EN : when defined, every 4th paddle hit raises the ball speed by
//                one up to BALL_SPEED_MAX; otherwise the speed is fixed.
// ---------------------------------------------------------------------------
module paddle_game_engine #(
    parameter int H_RES          = 640,
    parameter int V_RES          = 480,
    parameter int BALL_SIZE      = 10,
    parameter int BALL_SPEED     = 5,
    parameter int BALL_SPEED_MAX = 9,
    parameter int PDL_WIDTH      = 50,
    parameter int PDL_HEIGHT     = 10,
    parameter int PDL_SPEED      = 4,
    parameter int LIVES          = 3,
    parameter int SERVE_FRAMES   = 60,
    parameter int MISS_FRAMES    = 30,
    parameter int COLOR_W        = 8
) (
    input  logic               pix_clk,
    input  logic               reset,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_serve,
    input  logic [9:0]         x_pix,
    input  logic [9:0]         y_pix,
    input  logic               de_in,
    output logic               de_out,
    output logic [COLOR_W-1:0] r_out,
    output logic [COLOR_W-1:0] g_out,
    output logic [COLOR_W-1:0] b_out,
    output logic [2:0]         game_state,
    output logic [3:0]         lives_left,
    output logic [7:0]         score
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    // 11-bit geometry so that position + size + speed never wraps
    localparam int CW = 11;
    localparam logic [CW-1:0] HR       = CW'(H_RES);
    localparam logic [CW-1:0] VR       = CW'(V_RES);
    localparam logic [CW-1:0] BS       = CW'(BALL_SIZE);
    localparam logic [CW-1:0] PW       = CW'(PDL_WIDTH);
    localparam logic [CW-1:0] PS       = CW'(PDL_SPEED);
    localparam logic [CW-1:0] BSPD     = CW'(BALL_SPEED);
    localparam logic [CW-1:0] PDL_MAX  = CW'(H_RES - PDL_WIDTH);
    localparam logic [CW-1:0] PDL_INIT = CW'((H_RES - PDL_WIDTH) / 2);
    localparam logic [CW-1:0] PARK_OFS = CW'((PDL_WIDTH - BALL_SIZE) / 2);
    localparam logic [CW-1:0] PARK_Y   = CW'(V_RES - PDL_HEIGHT - BALL_SIZE);
    localparam logic [CW-1:0] PDL_TOP  = CW'(V_RES - PDL_HEIGHT);
    localparam logic [15:0]   SERVE_LD = 16'(SERVE_FRAMES);
    localparam logic [15:0]   MISS_LD  = 16'(MISS_FRAMES);
    localparam logic [3:0]    LIVES_LD = 4'(LIVES);
    localparam int            NREP     = (COLOR_W + 3) / 4;

    if (LIVES < 1 || LIVES > 15 || COLOR_W < 4 || BALL_SPEED_MAX < BALL_SPEED) begin : g_param_chk
        $error("paddle_game_engine: parameter set out of range");
    end

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_e          state_q;
    logic [3:0]      lives_q;
    logic [7:0]      score_q;
    logic [15:0]     cnt_q;
    logic [CW-1:0]   pdl_q;
    logic [CW-1:0]   qx_q, qy_q;
    logic            qdx_q;   // 0 = right, 1 = left
    logic            qdy_q;   // 1 = up,    0 = down
    logic [CW-1:0]   spd;

`ifdef SPEEDUP_EN
    logic [CW-1:0]   spd_q;
    localparam logic [CW-1:0] BSMAX = CW'(BALL_SPEED_MAX);
    assign spd = spd_q;
`else
    assign spd = BSPD;
`endif

    logic            frame_tick;
    assign frame_tick = ({1'b0, y_pix} == VR) && (x_pix == 10'd0);

    // ---------------------------------------------------------------------
    // Paddle next position (applied only on frame ticks in IDLE/SERVE/PLAY)
    // ---------------------------------------------------------------------
    logic [CW-1:0] pdl_d;
    always_comb begin
        pdl_d = pdl_q;
        if (btn_left && !btn_right)
            pdl_d = (pdl_q < PS) ? '0 : pdl_q - PS;
        else if (btn_right && !btn_left)
            pdl_d = (pdl_q + PS > PDL_MAX) ? PDL_MAX : pdl_q + PS;
    end

    // ---------------------------------------------------------------------
    // Ball physics for one PLAY frame; collision uses the paddle position
    // as it stood before this tick's paddle move.
    // ---------------------------------------------------------------------
    logic [CW-1:0] qx_d, qy_d;
    logic          qdx_d, qdy_d;
    logic          overlap, hit, miss;
    logic [7:0]    score_inc;

    assign overlap   = (qx_q + BS > pdl_q) && (qx_q < pdl_q + PW);
    assign score_inc = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;

    always_comb begin
        qx_d  = qx_q;
        qy_d  = qy_q;
        qdx_d = qdx_q;
        qdy_d = qdy_q;
        hit   = 1'b0;
        miss  = 1'b0;

        if (!qdx_q) begin
            if (qx_q + BS + spd >= HR) begin
                qx_d  = HR - BS;
                qdx_d = 1'b1;
            end else begin
                qx_d = qx_q + spd;
            end
        end else if (qx_q < spd) begin
            qx_d  = '0;
            qdx_d = 1'b0;
        end else begin
            qx_d = qx_q - spd;
        end

        if (qdy_q) begin
            if (qy_q < spd) begin
                qy_d  = '0;
                qdy_d = 1'b0;
            end else begin
                qy_d = qy_q - spd;
            end
        end else if (overlap && (qy_q + BS + spd >= PDL_TOP)) begin
            hit   = 1'b1;
            qy_d  = PARK_Y;
            qdy_d = 1'b1;
        end else if (!overlap && (qy_q + BS + spd >= VR)) begin
            miss  = 1'b1;   // ball leaves play; y is left where it was
        end else begin
            qy_d = qy_q + spd;
        end
    end

    // ---------------------------------------------------------------------
    // Game FSM with all game registers
    // ---------------------------------------------------------------------
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lives_q <= LIVES_LD;
            score_q <= '0;
            cnt_q   <= '0;
            pdl_q   <= PDL_INIT;
            qx_q    <= PDL_INIT + PARK_OFS;
            qy_q    <= PARK_Y;
            qdx_q   <= 1'b0;
            qdy_q   <= 1'b1;
`ifdef SPEEDUP_EN
            spd_q   <= BSPD;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_tick) begin
                        pdl_q <= pdl_d;
                        qx_q  <= pdl_d + PARK_OFS;
                        qy_q  <= PARK_Y;
                        qdx_q <= 1'b0;
                        qdy_q <= 1'b1;
                    end
                    if (btn_serve) begin
                        state_q <= ST_SERVE;
                        cnt_q   <= SERVE_LD;
`ifdef SPEEDUP_EN
                        spd_q   <= BSPD;
`endif
                    end
                end

                ST_SERVE: begin
                    if (frame_tick) begin
                        pdl_q <= pdl_d;
                        qx_q  <= pdl_d + PARK_OFS;
                        qy_q  <= PARK_Y;
                        qdx_q <= 1'b0;
                        qdy_q <= 1'b1;
                        if (cnt_q <= 16'd1) state_q <= ST_PLAY;
                        else                cnt_q   <= cnt_q - 16'd1;
                    end
                end

                ST_PLAY: begin
                    if (frame_tick) begin
                        pdl_q <= pdl_d;
                        qx_q  <= qx_d;
                        qdx_q <= qdx_d;
                        qy_q  <= qy_d;
                        qdy_q <= qdy_d;
                        if (miss) begin
                            state_q <= ST_MISS;
                            cnt_q   <= MISS_LD;
                            if (lives_q != 4'd0) lives_q <= lives_q - 4'd1;
                        end
                        if (hit) begin
                            score_q <= score_inc;
`ifdef SPEEDUP_EN
                            if (score_inc[1:0] == 2'd0 && spd_q < BSMAX)
                                spd_q <= spd_q + 1'b1;
`endif
                        end
                    end
                end

                ST_MISS: begin
                    if (frame_tick) begin
                        if (cnt_q <= 16'd1) begin
                            if (lives_q == 4'd0) begin
                                state_q <= ST_OVER;
                            end else begin
                                state_q <= ST_SERVE;
                                cnt_q   <= SERVE_LD;
                                qx_q    <= pdl_q + PARK_OFS;
                                qy_q    <= PARK_Y;
                                qdx_q   <= 1'b0;
                                qdy_q   <= 1'b1;
`ifdef SPEEDUP_EN
                                spd_q   <= BSPD;
`endif
                            end
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                end

                ST_OVER: begin
                    if (btn_serve) begin
                        state_q <= ST_IDLE;
                        lives_q <= LIVES_LD;
                        score_q <= '0;
                        qx_q    <= pdl_q + PARK_OFS;
                        qy_q    <= PARK_Y;
                        qdx_q   <= 1'b0;
                        qdy_q   <= 1'b1;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign game_state = state_q;
    assign lives_left = lives_q;
    assign score      = score_q;

    // ---------------------------------------------------------------------
    // Render: ball over paddle over background, one register stage
    // ---------------------------------------------------------------------
    function automatic logic [COLOR_W-1:0] expand(input logic [3:0] n);
        logic [4*NREP-1:0] rep;
        rep = {NREP{n}};
        return rep[4*NREP-1 -: COLOR_W];
    endfunction

    logic [CW-1:0] xe, ye;
    logic          in_ball, in_pdl;
    logic [11:0]   col;

    assign xe = {1'b0, x_pix};
    assign ye = {1'b0, y_pix};
    assign in_ball = (state_q != ST_MISS) &&
                     (xe >= qx_q) && (xe < qx_q + BS) &&
                     (ye >= qy_q) && (ye < qy_q + BS);
    assign in_pdl  = (xe >= pdl_q) && (xe < pdl_q + PW) &&
                     (ye >= PDL_TOP) && (ye < VR);

    always_comb begin
        col = (state_q == ST_OVER) ? 12'h700 : 12'h137;
        if (in_ball)     col = 12'hFFF;
        else if (in_pdl) col = 12'hF9F;
    end

    always_ff @(posedge pix_clk) begin
        if (reset) begin
            de_out <= 1'b0;
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
        end else begin
            de_out <= de_in;
            r_out  <= de_in ? expand(col[11:8]) : '0;
            g_out  <= de_in ? expand(col[7:4])  : '0;
            b_out  <= de_in ? expand(col[3:0])  : '0;
        end
    end

endmodule

// File: tb/tb_paddle_game_engine.sv
module tb_paddle_game_engine;

  localparam int H_RES = 640, V_RES = 480, B = 10, BSPD = 5, BSMAX = 9;
  localparam int PW = 50, PH = 10, PS = 4, LIVES = 3, SF = 60, MF = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_serve = 1'b0;
  logic [9:0] x_pix = '0, y_pix = '0;
  logic       de_in = 1'b0;
  logic       de_out;
  logic [7:0] r_out, g_out, b_out;
  logic [2:0] game_state;
  logic [3:0] lives_left;
  logic [7:0] score;

  paddle_game_engine #(
    .H_RES(H_RES), .V_RES(V_RES), .BALL_SIZE(B), .BALL_SPEED(BSPD),
    .BALL_SPEED_MAX(BSMAX), .PDL_WIDTH(PW), .PDL_HEIGHT(PH), .PDL_SPEED(PS),
    .LIVES(LIVES), .SERVE_FRAMES(SF), .MISS_FRAMES(MF), .COLOR_W(8)
  ) dut (
    .pix_clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
    .btn_serve(btn_serve), .x_pix(x_pix), .y_pix(y_pix), .de_in(de_in),
    .de_out(de_out), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .game_state(game_state), .lives_left(lives_left), .score(score)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (game rules in plain integers) -------
  // m_st: 0 idle, 1 serve, 2 play, 3 miss, 4 over
  int m_st, m_lives, m_score, m_cnt, m_pdl, m_qx, m_qy, m_dx, m_dy, m_spd;
  int exp_rgb, exp_de, obs_rgb;

  function automatic void m_park();
    m_qx = m_pdl + (PW - B) / 2; m_qy = V_RES - PH - B; m_dx = 0; m_dy = 1;
  endfunction

  function automatic void m_reset();
    m_st = 0; m_lives = LIVES; m_score = 0; m_cnt = 0; m_spd = BSPD;
    m_pdl = (H_RES - PW) / 2; m_park();
  endfunction

  function automatic void m_move(input bit l, input bit r);
    if (l && !r)      m_pdl = (m_pdl - PS < 0) ? 0 : m_pdl - PS;
    else if (r && !l) m_pdl = (m_pdl + PS > H_RES - PW) ? H_RES - PW : m_pdl + PS;
  endfunction

  function automatic void m_play();
    int  s = m_spd;
    bit  ovl = (m_qx + B > m_pdl) && (m_qx < m_pdl + PW);
    if (m_dx == 0) begin
      if (m_qx + B + s >= H_RES) begin m_qx = H_RES - B; m_dx = 1; end
      else m_qx += s;
    end else begin
      if (m_qx < s) begin m_qx = 0; m_dx = 0; end
      else m_qx -= s;
    end
    if (m_dy == 1) begin
      if (m_qy < s) begin m_qy = 0; m_dy = 0; end
      else m_qy -= s;
    end else if (ovl && m_qy + B + s >= V_RES - PH) begin
      m_qy = V_RES - PH - B; m_dy = 1;
      if (m_score < 255) m_score++;
`ifdef SPEEDUP_EN
      if (m_score % 4 == 0 && m_spd < BSMAX) m_spd++;
`endif
    end else if (!ovl && m_qy + B + s >= V_RES) begin
      m_st = 3; m_cnt = MF;
      if (m_lives > 0) m_lives--;
    end else m_qy += s;
  endfunction

  function automatic void m_step(input bit rst, l, r, srv, tk);
    if (rst) begin m_reset(); return; end
    case (m_st)
      0: begin
        if (tk) begin m_move(l, r); m_park(); end
        if (srv) begin m_st = 1; m_cnt = SF; m_spd = BSPD; end
      end
      1: if (tk) begin
        m_move(l, r); m_park();
        if (m_cnt <= 1) m_st = 2; else m_cnt--;
      end
      2: if (tk) begin m_play(); m_move(l, r); end
      3: if (tk) begin
        if (m_cnt <= 1) begin
          if (m_lives == 0) m_st = 4;
          else begin m_st = 1; m_cnt = SF; m_spd = BSPD; m_park(); end
        end else m_cnt--;
      end
      4: if (srv) begin m_st = 0; m_lives = LIVES; m_score = 0; m_park(); end
      default: m_st = 0;
    endcase
  endfunction

  function automatic int m_pix(input int x, input int y, input bit de);
    int c;
    if (!de) return 0;
    if (m_st != 3 && x >= m_qx && x < m_qx + B && y >= m_qy && y < m_qy + B) c = 'hFFF;
    else if (x >= m_pdl && x < m_pdl + PW && y >= V_RES - PH && y < V_RES) c = 'hF9F;
    else c = (m_st == 4) ? 'h700 : 'h137;
    return ((((c >> 8) & 15) * 17) << 16) | ((((c >> 4) & 15) * 17) << 8) | ((c & 15) * 17);
  endfunction

  // ---------------- stimulus ---------------------------------------------
  task automatic cyc(input bit rst, l, r, srv, tk, input int px, py, input bit de);
    @(negedge clk);
    reset = rst; btn_left = l; btn_right = r; btn_serve = srv; de_in = de;
    if (tk) begin x_pix = 10'd0; y_pix = 10'(V_RES); end
    else begin x_pix = px[9:0]; y_pix = py[9:0]; end
    @(posedge clk);
    exp_rgb = m_pix(px, py, de);   // render sees state from before this edge
    exp_de  = de;
    m_step(rst, l, r, srv, tk);
    #1;
    obs_rgb = {r_out, g_out, b_out};
  endtask

  task automatic probe(input string tag, input int px, py, input bit de);
    cyc(0, 0, 0, 0, 0, px, py, de);
    chk(tag, obs_rgb, exp_rgb);
  endtask

  task automatic frame(input bit l, r, srv);
    cyc(0, l, r, srv, 1, 0, 0, 0);
    chk("state", game_state, m_st);
    chk("lives", lives_left, m_lives);
    chk("score", score, m_score);
  endtask

  task automatic probe_all(input string tag);
    int rx, ry;
    bit rd;
    probe({tag, "_ball_tl"}, m_qx, m_qy, 1);
    probe({tag, "_ball_br"}, m_qx + B - 1, m_qy + B - 1, 1);
    probe({tag, "_ball_rout"}, m_qx + B, m_qy, 1);
    if (m_qx > 0) probe({tag, "_ball_lout"}, m_qx - 1, m_qy + B / 2, 1);
    probe({tag, "_pdl_l"}, m_pdl, V_RES - 1, 1);
    probe({tag, "_pdl_rout"}, m_pdl + PW, V_RES - 1, 1);
    if (m_pdl > 0) probe({tag, "_pdl_lout"}, m_pdl - 1, V_RES - PH, 1);
    rx = $urandom_range(0, H_RES - 1); ry = $urandom_range(0, V_RES - 1);
    rd = 1'($urandom_range(0, 1));
    probe({tag, "_rand"}, rx, ry, rd);
    chk({tag, "_de"}, de_out, exp_de);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    int  mode, steps;
    bit  l, r, srv;
    m_reset();

    // reset with a live ball pixel on the inputs: outputs must still be blank
    cyc(1, 0, 0, 0, 0, 315, 460, 1);
    chk("rst_de_out", de_out, 0);
    chk("rst_rgb", obs_rgb, 0);
    chk("rst_state", game_state, 0);
    chk("rst_lives", lives_left, 3);
    chk("rst_score", score, 0);
    probe_all("rst");
    probe("rst_park_const", 315, 460, 1);
    chk("rst_park_white", obs_rgb, 24'hFFFFFF);

    // paddle right in IDLE, then clamp
    repeat (10) frame(0, 1, 0);
    probe_all("idle_r10");
    probe("pdl335_const", 335, 475, 1);
    chk("pdl335_colour", obs_rgb, 24'hFF99FF);
    repeat (100) frame(0, 1, 0);
    probe_all("idle_clamp");
    probe("pdl_clamp_const", 639, 479, 1);
    chk("pdl_clamp_colour", obs_rgb, 24'hFF99FF);
    repeat (3) frame(1, 1, 0);        // both pressed: no move
    probe_all("idle_both");

    // serve countdown and first ball move
    do_reset();
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    chk("serve_state", game_state, 1);
    repeat (SF - 1) frame(0, 0, 0);
    chk("serve_59", game_state, 1);
    frame(0, 0, 0);
    chk("play_entry", game_state, 2);
    probe_all("play0");
    frame(0, 0, 0);
    probe_all("play1");
    probe("first_move_const", 320, 455, 1);
    chk("first_move_white", obs_rgb, 24'hFFFFFF);
    probe("first_move_prev", 319, 455, 1);
    chk("first_move_edge", obs_rgb, 24'h113377);

    // randomized play against the model
    mode = 0;
    for (int f = 0; f < 2500; f++) begin
      if (f % 150 == 0) mode = $urandom_range(0, 3);
      l = 0; r = 0;
      if (mode < 3) begin
        if (m_qx + B / 2 < m_pdl + PW / 2 - 4) l = 1;
        else if (m_qx + B / 2 > m_pdl + PW / 2 + 4) r = 1;
      end else begin
        if (m_qx + B / 2 < H_RES / 2) r = 1; else l = 1;
      end
      if ($urandom_range(0, 9) == 0) begin
        l = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
      end
      srv = ((m_st == 0 || m_st == 4) && $urandom_range(0, 3) == 0) ||
            ($urandom_range(0, 63) == 0);
      if (srv && $urandom_range(0, 1) == 1) begin
        cyc(0, 0, 0, 1, 0, 10, 10, 1);
        chk("rand_srv_state", game_state, m_st);
        srv = 0;
      end
      frame(l, r, srv);
      probe_all("rand");
    end

    // run out of lives by steering away from the ball
    do_reset();
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    steps = 0;
    while (m_st != 4 && steps < 8000) begin
      l = 0; r = 0;
      if (m_st == 2) begin
        if (m_qx + B / 2 < H_RES / 2) r = 1; else l = 1;
      end
      frame(l, r, 0);
      steps++;
    end
    chk("over_reached", game_state, 4);
    chk("over_lives", lives_left, 0);
    probe("over_bg", 0, 0, 1);
    chk("over_bg_const", obs_rgb, 24'h770000);
    probe_all("over");
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    chk("restart_state", game_state, 0);
    chk("restart_lives", lives_left, 3);
    chk("restart_score", score, 0);
    probe_all("restart");

    // reset in PLAY coinciding with a frame tick
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    repeat (SF + 7) frame(0, 0, 0);
    chk("midplay_state", game_state, 2);
    cyc(1, 0, 1, 0, 1, 0, 0, 0);
    chk("midrst_state", game_state, 0);
    chk("midrst_lives", lives_left, 3);
    chk("midrst_score", score, 0);
    chk("midrst_de", de_out, 0);
    probe_all("midrst");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/paddle_game_engine.md
Name: paddle_game_engine

Overview:
- Parametrised ball-and-paddle game core; successor to the fixed-size single-bounce demo top.
- Sits after the VGA timing controller: consumes pixel coordinates and DE, and produces registered RGB/DE for the SDL/VGA output stage.
- Adds paddle collision, miss detection, lives, score, a serve countdown and a game-over state.
- Resolution, object sizes, speeds and colour depth are all parameters.

Parameters:
- H_RES, 640, active pixels per line.
- V_RES, 480, active lines.
- BALL_SIZE, 10, ball edge length in pixels.
- BALL_SPEED, 5, ball pixels moved per frame, each axis.
- BALL_SPEED_MAX, 9, speed ceiling; used only when SPEEDUP_EN is defined.
- PDL_WIDTH, 50, paddle width in pixels.
- PDL_HEIGHT, 10, paddle height; paddle occupies the bottom PDL_HEIGHT lines.
- PDL_SPEED, 4, paddle pixels moved per frame.
- LIVES, 3, lives at game start (1..15).
- SERVE_FRAMES, 60, countdown length in SERVE state, in frames.
- MISS_FRAMES, 30, hold time in MISS state, in frames.
- COLOR_W, 8, bits per colour channel (>=4).

Ports:
- pix_clk, in, 1, pixel clock.
- reset, in, 1, synchronous, active-high.
- btn_left, in, 1, move paddle left (synchronised level).
- btn_right, in, 1, move paddle right.
- btn_serve, in, 1, start or restart game.
- x_pix, in, 10, current horizontal count from the timing controller.
- y_pix, in, 10, current vertical count.
- de_in, in, 1, display enable from the timing controller.
- de_out, out, 1, de_in delayed by 1 cycle.
- r_out / g_out / b_out, out, COLOR_W each, pixel colour.
- game_state, out, 3, current FSM state encoding.
- lives_left, out, 4, remaining lives.
- score, out, 8, paddle hits, saturating at 255.

Behaviour:
- Frame tick: asserted for exactly one cycle when y_pix==V_RES && x_pix==0. All motion updates happen only on frame ticks.

Reset (synchronous; wins over any simultaneous event, including mid-PLAY):
- State IDLE, lives_left=LIVES, score=0.
- pdl_l=(H_RES-PDL_WIDTH)/2.
- Ball parked: qx=pdl_l+(PDL_WIDTH-BALL_SIZE)/2, qy=V_RES-PDL_HEIGHT-BALL_SIZE, qdx=0 (right), qdy=1 (up).
- de_out=0 and r/g/b=0 on the cycle after reset.

FSM encodings: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4. Values 5-7 go to IDLE on the next cycle.
- IDLE: btn_serve high on any cycle -> SERVE; countdown loads SERVE_FRAMES.
- SERVE: countdown decrements on each frame tick. The frame tick that finds it at 1 -> PLAY. Ball physics starts on the next frame tick.
- PLAY: ball physics runs. A miss -> MISS, lives_left decrements on entry, countdown loads MISS_FRAMES.
- MISS: countdown reaches 0 -> OVER if lives_left==0, else SERVE with SERVE_FRAMES and the ball re-parked.
- OVER: btn_serve -> IDLE with lives_left=LIVES, score=0, ball re-parked.

Paddle (frame ticks, in IDLE/SERVE/PLAY only):
- btn_left alone: pdl_l -= PDL_SPEED, clamped at 0.
- btn_right alone: pdl_l += PDL_SPEED, clamped at H_RES-PDL_WIDTH.
- Both or neither pressed: no move.
- In IDLE and SERVE the ball tracks the paddle using the park formula.

Ball (PLAY frame ticks, speed s):
- X axis: wall bounce. If qx+BALL_SIZE+s >= H_RES, set qx=H_RES-BALL_SIZE and qdx=1. If qx<s when moving left, set qx=0 and qdx=0.
- Top: if qy<s when moving up, set qy=0 and qdy=0.
- Paddle hit: moving down, qy+BALL_SIZE+s >= V_RES-PDL_HEIGHT, and horizontal overlap (qx+BALL_SIZE>pdl_l && qx<pdl_l+PDL_WIDTH). Then qy=V_RES-PDL_HEIGHT-BALL_SIZE, qdy=1, score+1.
- Miss: moving down, no paddle overlap, and qy+BALL_SIZE+s >= V_RES.
- X and Y resolve in the same tick.
- Intermediate sums use 11-bit width to avoid wrap.

Render:
- Registered, latency 1 cycle from x_pix/y_pix/de_in.
- Priority: ball 0xFFF, then paddle 0xF9F, then background (0x137, or 0x700 in OVER).
- Ball is hidden in MISS.
- Each 4-bit nibble is expanded to COLOR_W by replication, truncated to COLOR_W.
- r/g/b are forced to 0 when de_in=0.

Optional Feature:
- SPEEDUP_EN defined:
  - Every 4th paddle hit (score%4==0 after increment) raises s by 1, up to BALL_SPEED_MAX.
  - s reloads to BALL_SPEED on entry to SERVE and on reset.
- Undefined: s is constant at BALL_SPEED and no speed register is synthesised.

Test Plan:
- Reset -> state 0, lives 3, score 0, pdl_l 295, ball (315,460), de_out=0 and rgb=0 the next cycle.
- IDLE, btn_right held 10 frames -> pdl_l 335, ball qx 355. Hold 100 more frames -> pdl_l clamps at 590.
- btn_serve pulse -> SERVE. After 60 frame ticks -> PLAY. First PLAY tick moves ball (315,460) to (320,455).
- Paddle placed under a descending ball -> qy snaps to 460, qdy=1, score 0 to 1. Ball at x=0 moving left -> qdx flips to 0.
- Paddle held far away, three misses -> lives 3,2,1,0, then OVER after 30 MISS frames, background 0x700. btn_serve -> IDLE with lives 3.
- Reset asserted mid-PLAY together with a frame tick -> all reset values on the next cycle. With SPEEDUP_EN and 4 hits -> speed 6.
